// File: rtl/dispatch_scheduler.sv
// Buffers decoded ops in a small FIFO and dispatches one per cycle, round-robin, to a free reservation station.
// Optional stall counter output stallCycles is built when DISPATCH_STATS_EN is defined.
module dispatch_scheduler #(
    parameter int NUM_RS = 4,
    parameter int OP_W   = 57,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [OP_W-1:0]   inOperation,
    input  logic              inValid,
    output logic              inReady,
    input  logic              flush,
    input  logic [NUM_RS-1:0] rsReady,
    output logic [NUM_RS-1:0] rsWrite,
    output logic [OP_W-1:0]   rsOperation,
    output logic              empty
`ifdef DISPATCH_STATS_EN
    ,
    output logic [15:0]       stallCycles
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int RR_W  = $clog2(NUM_RS);

    logic [OP_W-1:0]  mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [RR_W-1:0]  rr_q, rr_d;

    logic [OP_W-1:0]  head;
    logic             head_vld;
    logic             head_bubble;
    logic             found;
    logic [RR_W-1:0]  sel;
    logic [RR_W-1:0]  cand;
    logic             dispatch;
    logic             push;
    logic             pop;

    assign head        = mem_q[rd_ptr_q];
    assign head_vld    = (count_q != '0) && head[OP_W-1];
    assign head_bubble = (count_q != '0) && !head[OP_W-1];
    assign rsOperation = head;
    assign empty       = (count_q == '0);
    assign inReady     = (count_q != CNT_W'(DEPTH)) && !flush;

    // First ready station at or after rr, wrapping modulo NUM_RS.
    always_comb begin
        found = 1'b0;
        sel   = '0;
        cand  = '0;
        for (int k = 0; k < NUM_RS; k++) begin
            cand = RR_W'((int'(rr_q) + k) % NUM_RS);
            if (!found && rsReady[cand]) begin
                found = 1'b1;
                sel   = cand;
            end
        end
    end

    assign dispatch = !flush && head_vld && found;
    assign pop      = dispatch || (!flush && head_bubble);
    assign push     = inValid && inReady;

    always_comb begin
        rsWrite = '0;
        if (dispatch) begin
            rsWrite[sel] = 1'b1;
        end
    end

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        rr_d     = rr_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
            if (dispatch) begin
                rr_d = (sel == RR_W'(NUM_RS - 1)) ? '0 : sel + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            rr_q     <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            rr_q     <= rr_d;
        end
    end

    // Storage carries no reset; occupancy is tracked solely by count_q.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= inOperation;
        end
    end

`ifdef DISPATCH_STATS_EN
    logic [15:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if (flush) begin
            stall_d = '0;
        end else if (head_vld && !found && (stall_q != 16'hFFFF)) begin
            stall_d = stall_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stallCycles = stall_q;
`endif

endmodule
